multicyc_mcu_hs: RTL

Full multicycle MIPS main control FSM with a parametrised memory handshake, replacing the fetch-only controller. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type (add/sub/and/or/slt), addi, beq, bne and j. It sits beside the multicycle datapath. It drives mux selects, write enables and the ALU op. When MEM_HS=1 it stalls on a variable-latency memory.

---
 rtl/multicyc_mcu_hs_pkg.sv | 52 +++++
 rtl/multicyc_mcu_hs_if.sv | 36 +++
 rtl/multicyc_mcu_hs_alu_funct_dec.sv | 22 ++
 rtl/multicyc_mcu_hs.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/multicyc_mcu_hs_pkg.sv
// rtl/multicyc_mcu_hs_pkg.sv - ALU op, opcode and control-select constants for the multicycle controller
package ALUops;
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
endpackage

package Opcodes;
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
endpackage

package MultcycCtrl;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic       AddrPC   = 1'b0;
    localparam logic       AddrALU  = 1'b1;
    localparam logic       SrcaPC   = 1'b0;
    localparam logic       SrcaReg  = 1'b1;
    localparam logic [1:0] RegB     = 2'd0;
    localparam logic [1:0] Four     = 2'd1;
    localparam logic [1:0] Imm      = 2'd2;
    localparam logic [1:0] ImmSh2   = 2'd3;
    localparam logic [1:0] PcAlu    = 2'd0;
    localparam logic [1:0] PcAluOut = 2'd1;
    localparam logic [1:0] PcJump   = 2'd2;
endpackage

// File: rtl/multicyc_mcu_hs_if.sv
// rtl/multicyc_mcu_hs_if.sv - controller <-> datapath/memory signal bundle
interface multicyc_mcu_hs_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       mdr_we;
    logic       alu_srca_sel;
    logic [1:0] alu_srcb_sel;
    logic [3:0] aluop;
    logic [1:0] pc_src_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_we;
    logic       pc_we;
    logic       wreg_dst_sel;
    logic       wrbck_data_sel;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_addr_sel, ir_we, mdr_we, alu_srca_sel, alu_srcb_sel, aluop,
               pc_src_sel, mem_rd, mem_wr, reg_we, pc_we, wreg_dst_sel,
               wrbck_data_sel, illegal_op, state_o
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_addr_sel, ir_we, mdr_we, alu_srca_sel, alu_srcb_sel, aluop,
               pc_src_sel, mem_rd, mem_wr, reg_we, pc_we, wreg_dst_sel,
               wrbck_data_sel, illegal_op, state_o
    );
endinterface

// File: rtl/multicyc_mcu_hs_alu_funct_dec.sv
// rtl/multicyc_mcu_hs_alu_funct_dec.sv - R-type funct to ALU op map with supported flag
module alu_funct_dec
    import ALUops::*;
    import Opcodes::*;
(
    input  logic [5:0] funct,
    output logic [3:0] aluop,
    output logic       valid
);
    always_comb begin
        aluop = ALU_AND;
        valid = 1'b1;
        case (funct)
            FUNCT_ADD: aluop = ALU_ADD;
            FUNCT_SUB: aluop = ALU_SUB;
            FUNCT_AND: aluop = ALU_AND;
            FUNCT_OR:  aluop = ALU_OR;
            FUNCT_SLT: aluop = ALU_SLT;
            default:   valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicyc_mcu_hs.sv
// rtl/multicyc_mcu_hs.sv - multicycle MIPS main control FSM with memory ready handshake
module multicyc_mcu_hs
    import ALUops::*;
    import Opcodes::*;
    import MultcycCtrl::*;
#(
    parameter bit MEM_HS  = 1'b1,
    parameter bit EN_BNE  = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    multicyc_mcu_hs_if.master bus
);
    state_t     state, state_next;
    logic       rdy;
    logic [3:0] fd_aluop;
    logic       fd_valid;
    state_t     dec_target;
    logic       dec_illegal;

    logic       addr_c, ir_we_c, mdr_we_c, srca_c, mem_rd_c, mem_wr_c;
    logic       reg_we_c, pc_we_c, dst_c, wb_c, illegal_c;
    logic [1:0] srcb_c, pc_src_c;
    logic [3:0] aluop_c;

    assign rdy = MEM_HS ? bus.mem_ready : 1'b1;

    alu_funct_dec u_funct_dec (
        .funct (bus.funct),
        .aluop (fd_aluop),
        .valid (fd_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Opcode dispatch out of Decode; anything unrecognised returns to Fetch
    always_comb begin
        dec_target  = S_FETCH;
        dec_illegal = 1'b0;
        case (bus.opcode)
            OP_LW, OP_SW: dec_target = S_MEMADR;
            OP_RTYPE:     if (fd_valid) dec_target = S_EXECUTE; else dec_illegal = 1'b1;
            OP_ADDI:      dec_target = S_ADDIEXEC;
            OP_BEQ:       dec_target = S_BRANCH;
            OP_BNE:       if (EN_BNE) dec_target = S_BRANCH; else dec_illegal = 1'b1;
            OP_J:         if (EN_JUMP) dec_target = S_JUMP; else dec_illegal = 1'b1;
            default:      dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        addr_c     = AddrPC;
        ir_we_c    = 1'b0;
        mdr_we_c   = 1'b0;
        srca_c     = SrcaPC;
        srcb_c     = RegB;
        aluop_c    = ALU_AND;
        pc_src_c   = PcAlu;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        reg_we_c   = 1'b0;
        pc_we_c    = 1'b0;
        dst_c      = 1'b0;
        wb_c       = 1'b0;
        illegal_c  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd_c   = 1'b1;
                srcb_c     = Four;
                aluop_c    = ALU_ADD;
                ir_we_c    = rdy;
                pc_we_c    = rdy;
                state_next = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                srcb_c     = ImmSh2;
                aluop_c    = ALU_ADD;
                illegal_c  = dec_illegal;
                state_next = dec_target;
            end
            S_MEMADR: begin
                srca_c     = SrcaReg;
                srcb_c     = Imm;
                aluop_c    = ALU_ADD;
                state_next = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_rd_c   = 1'b1;
                addr_c     = AddrALU;
                mdr_we_c   = rdy;
                state_next = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                reg_we_c   = 1'b1;
                wb_c       = 1'b1;
            end
            S_MEMWRITE: begin
                mem_wr_c   = 1'b1;
                addr_c     = AddrALU;
                state_next = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                srca_c     = SrcaReg;
                aluop_c    = fd_aluop;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we_c   = 1'b1;
                dst_c      = 1'b1;
            end
            // IR is stable from Decode onward, so opcode still tells beq from bne here
            S_BRANCH: begin
                srca_c     = SrcaReg;
                aluop_c    = ALU_SUB;
                pc_src_c   = PcAluOut;
                pc_we_c    = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
            end
            S_ADDIEXEC: begin
                srca_c     = SrcaReg;
                srcb_c     = Imm;
                aluop_c    = ALU_ADD;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: reg_we_c = 1'b1;
            S_JUMP: begin
                pc_src_c   = PcJump;
                pc_we_c    = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are suppressed while reset is held so an abandoned access never commits
    assign bus.ir_we          = ir_we_c   & ~reset;
    assign bus.mdr_we         = mdr_we_c  & ~reset;
    assign bus.pc_we          = pc_we_c   & ~reset;
    assign bus.reg_we         = reg_we_c  & ~reset;
    assign bus.mem_rd         = mem_rd_c  & ~reset;
    assign bus.mem_wr         = mem_wr_c  & ~reset;
    assign bus.illegal_op     = illegal_c & ~reset;
    assign bus.mem_addr_sel   = addr_c;
    assign bus.alu_srca_sel   = srca_c;
    assign bus.alu_srcb_sel   = srcb_c;
    assign bus.aluop          = aluop_c;
    assign bus.pc_src_sel     = pc_src_c;
    assign bus.wreg_dst_sel   = dst_c;
    assign bus.wrbck_data_sel = wb_c;
    assign bus.state_o        = state;
endmodule
